// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate M-stage
// data cache controller. Owns tags/valids and drives the data array and memory.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i   M-stage access (we: 0 ld, 1 SB, 2 SH, 3 SW)
//   cpu_rdata_o, stall_o            load word, pipeline-wide stall
//   dary_*                          external data array (async read)
//   mem_*                           backing memory, beat on req & ready
module dcache_ctrl #(
  parameter int INDEX_BITS     = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_i,
  input  logic [2:0]            cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  stall_o,
  output logic [INDEX_BITS+$clog2(WORDS_PER_LINE)-1:0] dary_addr_o,
  output logic                  dary_we_o,
  output logic [3:0]            dary_be_o,
  output logic [31:0]           dary_wdata_o,
  input  logic [31:0]           dary_rdata_i,
  output logic                  mem_req_o,
  output logic [2:0]            mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
  localparam int TAG_LSB  = 2 + OFF_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    DONE
  } state_t;

  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [OFF_BITS-1:0]   beat_q;
  logic [TAG_BITS-1:0]   ltag_q;
  logic [INDEX_BITS-1:0] lidx_q;
  logic [31:0]           laddr_q;
  logic [31:0]           lwdata_q;
  logic [2:0]            lsize_q;
  logic                  lhit_q;

  logic [INDEX_BITS-1:0] idx;
  logic [OFF_BITS-1:0]   wrd;
  logic [TAG_BITS-1:0]   tag;
  logic                  is_st;
  logic                  ld_req;
  logic                  st_req;
  logic                  hit;
  logic                  last_beat;
  logic [3:0]            st_be;
  logic [31:0]           st_data;

  assign idx    = cpu_addr_i[2+OFF_BITS +: INDEX_BITS];
  assign wrd    = cpu_addr_i[2 +: OFF_BITS];
  assign tag    = cpu_addr_i[31:TAG_LSB];
  assign is_st  = (cpu_we_i == 3'd1) | (cpu_we_i == 3'd2)
                | (cpu_we_i == 3'd3);
  assign ld_req = cpu_req_i & ~is_st;
  assign st_req = cpu_req_i & is_st;
  assign hit    = valid_q[idx] & (tag_q[idx] == tag);

  assign last_beat =
    (beat_q == OFF_BITS'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      beat_q   <= '0;
      ltag_q   <= '0;
      lidx_q   <= '0;
      laddr_q  <= '0;
      lwdata_q <= '0;
      lsize_q  <= '0;
      lhit_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ld_req & ~hit) begin
            ltag_q       <= tag;
            lidx_q       <= idx;
            valid_q[idx] <= 1'b0;
            beat_q       <= '0;
            state_q      <= REFILL;
          end else if (st_req) begin
            laddr_q  <= cpu_addr_i;
            lwdata_q <= cpu_wdata_i;
            lsize_q  <= cpu_we_i;
            lhit_q   <= hit;
            state_q  <= WRITE;
          end
        end
        REFILL: begin
          if (mem_ready_i) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              valid_q[lidx_q] <= 1'b1;
              state_q         <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ready_i) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag only matters once valid is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_ready_i && last_beat)
      tag_q[lidx_q] <= ltag_q;
  end

  always_comb begin
    st_be   = 4'hF;
    st_data = lwdata_q;
    unique case (1'b1)
      (lsize_q == 3'd1): begin
        st_be   = 4'b0001 << laddr_q[1:0];
        st_data = {4{lwdata_q[7:0]}};
      end
      (lsize_q == 3'd2): begin
        st_be   = laddr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{lwdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'hF;
        st_data = lwdata_q;
      end
    endcase
  end

  // Outputs are forced low while reset is held so the pipeline
  // and memory see the abort immediately.
  always_comb begin
    stall_o      = 1'b0;
    cpu_rdata_o  = '0;
    dary_addr_o  = {idx, wrd};
    dary_we_o    = 1'b0;
    dary_be_o    = '0;
    dary_wdata_o = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (ld_req & hit) cpu_rdata_o = dary_rdata_i;
          stall_o = (ld_req & ~hit) | st_req;
        end
        REFILL: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {ltag_q, lidx_q, beat_q, 2'b00};
          dary_addr_o = {lidx_q, beat_q};
          if (mem_ready_i) begin
            dary_we_o    = 1'b1;
            dary_be_o    = 4'hF;
            dary_wdata_o = mem_rdata_i;
          end
        end
        WRITE: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = lsize_q;
          mem_addr_o  = laddr_q;
          mem_wdata_o = lwdata_q;
          if (mem_ready_i & lhit_q) begin
            dary_we_o    = 1'b1;
            dary_be_o    = st_be;
            dary_wdata_o = st_data;
          end
        end
        DONE: begin
          stall_o = 1'b0;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with memory
// and data-array models, configurable ready gaps and reset abort.
module tb_dcache_ctrl;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i;
  logic [2:0]  cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        stall_o;
  logic [5:0]  dary_addr_o;
  logic        dary_we_o;
  logic [3:0]  dary_be_o;
  logic [31:0] dary_wdata_o;
  logic [31:0] dary_rdata_i;
  logic        mem_req_o;
  logic [2:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .INDEX_BITS(4),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_req_i(cpu_req_i),
    .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .stall_o(stall_o),
    .dary_addr_o(dary_addr_o),
    .dary_we_o(dary_we_o),
    .dary_be_o(dary_be_o),
    .dary_wdata_o(dary_wdata_o),
    .dary_rdata_i(dary_rdata_i),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  typedef struct packed {
    logic [2:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } mtx_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } dtx_t;

  mtx_t        mem_q [$];
  dtx_t        dary_q [$];
  logic [31:0] ld_q [$];

  logic [31:0] dary_m [64];
  logic [31:0] mem_m [int unsigned];

  int checks = 0;
  int errors = 0;
  int gap = 1;
  int wcnt = 0;
  int beats = 0;

  assign dary_rdata_i = dary_m[dary_addr_o];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = int'(a >> 2);
    if (mem_m.exists(k)) return mem_m[k];
    return 32'hD000_0000 | {a[31:2], 2'b00};
  endfunction

  // memory responder: ready after 'gap' idle cycles per beat
  always @(posedge clk) begin
    #2;
    if (mem_req_o) begin
      mem_rdata_i = mem_rd(mem_addr_o);
      if (wcnt >= gap) begin
        mem_ready_i = 1'b1;
        wcnt = 0;
      end else begin
        mem_ready_i = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      wcnt = 0;
    end
  end

  mtx_t        me;
  dtx_t        de;
  logic [31:0] w;

  // monitor: pop scoreboard on each beat / array write
  always @(negedge clk) begin
    if (rst_n && mem_req_o && mem_ready_i) begin
      chk("mem_pend", {31'b0, mem_q.size() != 0}, 32'd1);
      if (mem_q.size() != 0) begin
        me = mem_q.pop_front();
        chk("mem_we", {29'b0, mem_we_o}, {29'b0, me.we});
        chk("mem_addr", mem_addr_o, me.addr);
        if (me.we != 3'd0) begin
          chk("mem_wdata", mem_wdata_o, me.data);
          w = mem_rd(me.addr);
          case (me.we)
            3'd1: w[8*me.addr[1:0] +: 8] = me.data[7:0];
            3'd2: w[16*me.addr[1] +: 16] = me.data[15:0];
            default: w = me.data;
          endcase
          mem_m[int'(me.addr >> 2)] = w;
        end
      end
    end
    if (dary_we_o) begin
      beats++;
      chk("dary_pend", {31'b0, dary_q.size() != 0}, 32'd1);
      if (dary_q.size() != 0) begin
        de = dary_q.pop_front();
        chk("dary_addr", {26'b0, dary_addr_o}, {26'b0, de.addr});
        chk("dary_be", {28'b0, dary_be_o}, {28'b0, de.be});
        chk("dary_wdata", dary_wdata_o, de.data);
      end
      w = dary_m[dary_addr_o];
      for (int i = 0; i < 4; i++)
        if (dary_be_o[i]) w[8*i +: 8] = dary_wdata_o[8*i +: 8];
      dary_m[dary_addr_o] = w;
    end
  end

  task automatic push_refill(input logic [31:0] a);
    logic [31:0] line;
    line = a & ~32'hF;
    for (int b = 0; b < WPL; b++) begin
      mem_q.push_back(mtx_t'{3'd0, line + 32'(4 * b), 32'h0});
      dary_q.push_back(dtx_t'{{a[7:4], 2'(b)}, 4'hF,
                              mem_rd(line + 32'(4 * b))});
    end
  endtask

  task automatic do_load(input logic [31:0] a,
                         input logic [31:0] exp,
                         input bit miss);
    int n;
    n = 0;
    if (miss) push_refill(a);
    ld_q.push_back(exp);
    cpu_req_i   = 1'b1;
    cpu_we_i    = 3'd0;
    cpu_addr_i  = a;
    cpu_wdata_i = $urandom;
    @(negedge clk);
    while (stall_o && n < 200) begin
      chk("ld_rdata_stall", cpu_rdata_o, 32'h0);
      n++;
      @(negedge clk);
    end
    chk("ld_cycles", 32'(n),
        miss ? 32'(1 + WPL * (gap + 1)) : 32'd0);
    chk("ld_data", cpu_rdata_o, ld_q.pop_front());
    chk("ld_mem_q", 32'(mem_q.size()), 32'd0);
    chk("ld_dary_q", 32'(dary_q.size()), 32'd0);
    @(posedge clk);
    #1 cpu_req_i = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] we,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input bit hit);
    int n;
    logic [3:0]  be;
    logic [31:0] rep;
    n = 0;
    case (we)
      3'd1: begin
        be  = 4'b0001 << a[1:0];
        rep = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end
      3'd2: begin
        be  = a[1] ? 4'b1100 : 4'b0011;
        rep = {d[15:0], d[15:0]};
      end
      default: begin
        be  = 4'hF;
        rep = d;
      end
    endcase
    mem_q.push_back(mtx_t'{we, a, d});
    if (hit) dary_q.push_back(dtx_t'{a[7:2], be, rep});
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    @(negedge clk);
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("st_cycles", 32'(n), 32'(gap + 2));
    chk("st_done_rdata", cpu_rdata_o, 32'h0);
    chk("st_mem_q", 32'(mem_q.size()), 32'd0);
    chk("st_dary_q", 32'(dary_q.size()), 32'd0);
    @(posedge clk);
    #1 cpu_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 3'd0;
    cpu_addr_i  = 32'h100;
    cpu_wdata_i = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 64; i++) dary_m[i] = '0;
    mem_m[32'h100 >> 2] = 32'hA0;
    mem_m[32'h104 >> 2] = 32'hA1;
    mem_m[32'h108 >> 2] = 32'hA2;
    mem_m[32'h10C >> 2] = 32'hA3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_dary_we", {31'b0, dary_we_o}, 32'd0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    cpu_req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    gap = 1;
    do_load(32'h100, 32'hA0, 1'b1);
    do_load(32'h108, 32'hA2, 1'b0);
    do_store(3'd1, 32'h101, 32'h0000_00AB, 1'b1);
    do_load(32'h100, 32'h0000_ABA0, 1'b0);
    do_store(3'd2, 32'h10A, 32'h0000_BEEF, 1'b1);
    do_load(32'h108, 32'hBEEF_00A2, 1'b0);

    gap = 0;
    do_store(3'd3, 32'h200, 32'h1357_9BDF, 1'b0);
    do_load(32'h100, 32'h0000_ABA0, 1'b0);
    do_load(32'h200, 32'h1357_9BDF, 1'b1);
    do_load(32'h20C, 32'hD000_020C, 1'b0);

    gap = 2;
    do_load(32'h1100, 32'hD000_1100, 1'b1);
    do_load(32'h100, 32'h0000_ABA0, 1'b1);
    do_load(32'h1104, 32'hD000_1104, 1'b1);

    // abort a refill of 0x100 after two beats
    gap = 1;
    beats = 0;
    push_refill(32'h100);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 3'd0;
    cpu_addr_i = 32'h100;
    n = 0;
    while (beats < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("abort_beats", 32'(beats), 32'd2);
    chk("abort_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("abort_stall", {31'b0, stall_o}, 32'd0);
    chk("abort_dary_we", {31'b0, dary_we_o}, 32'd0);
    chk("abort_rdata", cpu_rdata_o, 32'h0);
    cpu_req_i = 1'b0;
    mem_q.delete();
    dary_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_load(32'h100, 32'h0000_ABA0, 1'b1);
    do_load(32'h10C, 32'hA3, 1'b0);

    chk("end_mem_q", 32'(mem_q.size()), 32'd0);
    chk("end_dary_q", 32'(dary_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
